enc_bus: RTL and testbench
==========================

Name: enc_bus

Overview:
- Bus-mapped quadrature encoder reader; the feedback counterpart to the step/dir motor outputs.
- Samples per-axis A/B encoder lines, then synchronises, filters and x4-decodes them into 32-bit signed position counters.
- Counters are latched on the shared global_snapshot strobe; a per-axis enc_changed pulse feeds the motor block's delta_enc logic.
- Sits on the same 16-bit register bus as the motor block, in its own BAR window.

Parameters:
ENCODERS, 2, number of encoder channels (1..4)
BAR, 'h100, bus window base address
MASK, 'hFF, window address mask; local address = addr & MASK

Ports:
clk  input  1  system clock
sclr  input  1  synchronous active-high reset
rdaddr  input  16  read byte address
wraddr  input  16  write byte address
be  input  2  byte enables for write
write  input  1  write strobe
wrdata  input  16  write data
rddata  output  16  registered read data
enc_a  input  ENCODERS  raw encoder A lines (asynchronous)
enc_b  input  ENCODERS  raw encoder B lines (asynchronous)
enc_z  input  ENCODERS  raw index lines (used only with ENC_INDEX_EN)
global_snapshot  input  1  one-cycle snapshot strobe
enc_changed  output  ENCODERS  one-cycle pulse per count change
enc_error  output  1  OR of all sticky error flags

Behaviour:
- Reset (sclr at a clock edge): counts, snapshots and errors = 0; rddata = 0; enc_changed = 0; invert = 0; filter length FLT = 3; filter and decoder state reload from the current synchronised inputs, so no count is produced on reset release. Reset mid-transition discards any pending edge.
- Hit rule: rdhit/wrhit = (addr & ~MASK) == BAR.
- Input path, per line: 2-FF synchroniser, then glitch filter. The filtered value updates only after the synchronised value has differed from it for FLT+1 consecutive clocks. FLT = 0 gives 1-clock qualification.
- Decoder: compare previous and current filtered {A,B} each clock.
  - Forward sequence 00→01→11→10→00 gives +1; reverse sequence gives −1.
  - No change gives 0.
  - Both bits changing in one clock: no count, set sticky err[k].
  - invert[k] = 1 negates the step.
- Counter: 32-bit, modulo 2^32 wrap (0x7FFFFFFF+1 → 0x80000000; 0 − 1 → 0xFFFFFFFF).
  - enc_changed[k] = 1 in the same cycle the count register takes a ±1 update; it is registered.
- Snapshot: on global_snapshot, snap[k] <= count[k] (the pre-update value if an edge coincides).
- Per-channel register map, base = 0x10*k:
  - 0x0: count[15:0] (R/W)
  - 0x2: count[31:16] (R/W)
  - 0x4: snap[15:0] (RO)
  - 0x6: snap[31:16] (RO)
  - 0x8: index[15:0] (RO)
  - 0xA: index[31:16] (RO)
- Global registers:
  - 0x40: invert[ENCODERS-1:0] (R/W, be[0])
  - 0x42: err[ENCODERS-1:0] (read; write 1 to clear, be[0])
  - 0x44: FLT[3:0] (R/W, be[0])
  - Unmapped addresses read 0; writes to them are ignored.
- Count writes are byte-granular via be. A write and a decode step in the same cycle: the write wins and the step is dropped (enc_changed stays 0). Err clear and a new error in the same cycle: set wins.
- Read: 1-cycle latency. rddata = 0 when there is no rdhit.

Optional Feature:
- Macro: ENC_INDEX_EN.
- When defined:
  - enc_z is synchronised and filtered like A/B.
  - On a filtered Z rising edge, index[k] <= count[k] and flag idx_seen[k] is set.
  - idx_seen is readable at 0x46 (write 1 to clear).
- When undefined:
  - enc_z is unused.
  - 0x8/0xA/0x46 read 0.
  - No index logic is synthesised.

Test Plan:
- FLT=3, drive a full forward cycle 00→01→11→10→00, each state held 10 clk → count=4, four enc_changed pulses, each pulse 6 clk after its input edge (2 sync + 4 filter).
- Preset count to 0x00000000, then one reverse step → count=0xFFFFFFFF; preset to 0x7FFFFFFF, then one forward step → 0x80000000.
- Toggle A and B in the same clk → count unchanged, err[0]=1, enc_error=1; write 0x0001 to 0x42 → err cleared.
- 2-clk glitch on A with FLT=3 → no count change, no enc_changed pulse.
- global_snapshot in the same cycle as a +1 edge from count=100 → snap=100, count=101; reads of 0x4/0x6 return 100/0 one cycle after the address.
- ENC_INDEX_EN: Z rises at count=37 → index=37, idx_seen=1. Without the macro, reading 0x8 returns 0.

Source files
------------

// File: rtl/enc_bus.sv
// enc_bus: bus-mapped quadrature encoder reader; sync + glitch filter + x4 decode into 32-bit counters.
// Latency: count/enc_changed update 2 sync + FLT+1 filter clocks after an input edge; reads return 1 clk later.
// Backpressure: none, the register bus always accepts. Define ENC_INDEX_EN to add Z-index capture.
module enc_bus #(
  parameter int          ENCODERS = 2,
  parameter logic [15:0] BAR      = 16'h0100,
  parameter logic [15:0] MASK     = 16'h00FF
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic [15:0]         rdaddr,
  input  logic [15:0]         wraddr,
  input  logic [1:0]          be,
  input  logic                write,
  input  logic [15:0]         wrdata,
  output logic [15:0]         rddata,
  input  logic [ENCODERS-1:0] enc_a,
  input  logic [ENCODERS-1:0] enc_b,
  input  logic [ENCODERS-1:0] enc_z,
  input  logic                global_snapshot,
  output logic [ENCODERS-1:0] enc_changed,
  output logic                enc_error
);

  // Line layout: A lines at [k], B lines at [ENCODERS+k], Z lines (index build) at [2*ENCODERS+k].
`ifdef ENC_INDEX_EN
  localparam int NLINE = 3 * ENCODERS;
  logic [NLINE-1:0] raw;
  assign raw = {enc_z, enc_b, enc_a};
`else
  localparam int NLINE = 2 * ENCODERS;
  logic [NLINE-1:0] raw;
  logic             unused_enc_z;
  assign raw          = {enc_b, enc_a};
  assign unused_enc_z = ^enc_z;
`endif

  logic [NLINE-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NLINE-1:0]    flt_q, flt_d;
  logic [3:0]          fcnt_q [NLINE];
  logic [3:0]          fcnt_d [NLINE];
  logic [3:0]          flt_len_q, flt_len_d;
  logic [31:0]         count_q [ENCODERS];
  logic [31:0]         count_d [ENCODERS];
  logic [31:0]         snap_q [ENCODERS];
  logic [31:0]         snap_d [ENCODERS];
  logic [ENCODERS-1:0] invert_q, invert_d, err_q, err_d, chg_q, chg_d;
  logic [15:0]         rddata_q, rddata_d;

  logic [1:0]          dpos [ENCODERS];
  logic [ENCODERS-1:0] step_up, step_dn, bad, cnt_wr;
  logic                rd_hit, wr_hit, wr_en;
  logic [15:0]         rloc, wloc;

  assign rd_hit = (rdaddr & ~MASK) == BAR;
  assign wr_hit = (wraddr & ~MASK) == BAR;
  assign rloc   = rdaddr & MASK;
  assign wloc   = wraddr & MASK;
  assign wr_en  = write & wr_hit;

`ifdef ENC_INDEX_EN
  logic [31:0]         index_q [ENCODERS];
  logic [31:0]         index_d [ENCODERS];
  logic [ENCODERS-1:0] idx_seen_q, idx_seen_d;
`endif

  // Two-flop synchroniser for every raw line; deliberately not reset.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // Glitch filter: follow the synchronised value once it has differed for FLT+1 clocks.
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < NLINE; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != flt_q[i]) begin
        if (fcnt_q[i] >= flt_len_q) begin
          flt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // x4 decoder: Gray state mapped to a 2-bit position; +1/-1 steps count, a jump of 2 is an error.
  always_comb begin
    step_up = '0;
    step_dn = '0;
    bad     = '0;
    for (int k = 0; k < ENCODERS; k++) begin
      dpos[k]    = {flt_d[k], flt_d[k] ^ flt_d[ENCODERS+k]}
                 - {flt_q[k], flt_q[k] ^ flt_q[ENCODERS+k]};
      step_up[k] = (dpos[k] == 2'd1);
      step_dn[k] = (dpos[k] == 2'd3);
      bad[k]     = (dpos[k] == 2'd2);
    end
  end

  // Counters and snapshots; a bus write to a count word takes priority over a decode step.
  always_comb begin
    for (int k = 0; k < ENCODERS; k++) begin
      count_d[k] = count_q[k];
      snap_d[k]  = global_snapshot ? count_q[k] : snap_q[k];
      chg_d[k]   = 1'b0;
      cnt_wr[k]  = wr_en && (|be) &&
                   ((wloc == 16'(16 * k)) || (wloc == 16'(16 * k + 2)));
      if (cnt_wr[k]) begin
        if (wloc == 16'(16 * k)) begin
          if (be[0]) count_d[k][7:0]   = wrdata[7:0];
          if (be[1]) count_d[k][15:8]  = wrdata[15:8];
        end else begin
          if (be[0]) count_d[k][23:16] = wrdata[7:0];
          if (be[1]) count_d[k][31:24] = wrdata[15:8];
        end
      end else if (invert_q[k] ? step_dn[k] : step_up[k]) begin
        count_d[k] = count_q[k] + 32'd1;
        chg_d[k]   = 1'b1;
      end else if (invert_q[k] ? step_up[k] : step_dn[k]) begin
        count_d[k] = count_q[k] - 32'd1;
        chg_d[k]   = 1'b1;
      end
    end
  end

  // Global control registers; for the sticky error bits a new error beats a clear.
  always_comb begin
    invert_d  = invert_q;
    flt_len_d = flt_len_q;
    err_d     = err_q;
    if (wr_en && be[0] && (wloc == 16'h0040)) invert_d  = wrdata[ENCODERS-1:0];
    if (wr_en && be[0] && (wloc == 16'h0044)) flt_len_d = wrdata[3:0];
    if (wr_en && be[0] && (wloc == 16'h0042)) err_d = err_q & ~wrdata[ENCODERS-1:0];
    err_d = err_d | bad;
  end

`ifdef ENC_INDEX_EN
  // Index capture on a filtered Z rising edge; the seen flag clears by write-1, set wins.
  always_comb begin
    idx_seen_d = idx_seen_q;
    if (wr_en && be[0] && (wloc == 16'h0046)) idx_seen_d = idx_seen_q & ~wrdata[ENCODERS-1:0];
    for (int k = 0; k < ENCODERS; k++) begin
      index_d[k] = index_q[k];
      if (!flt_q[2*ENCODERS+k] && flt_d[2*ENCODERS+k]) begin
        index_d[k]    = count_q[k];
        idx_seen_d[k] = 1'b1;
      end
    end
  end
`endif

  // Read mux; anything outside the window or unmapped returns zero.
  always_comb begin
    rddata_d = '0;
    if (rd_hit) begin
      for (int k = 0; k < ENCODERS; k++) begin
        if (rloc == 16'(16 * k))     rddata_d = count_q[k][15:0];
        if (rloc == 16'(16 * k + 2)) rddata_d = count_q[k][31:16];
        if (rloc == 16'(16 * k + 4)) rddata_d = snap_q[k][15:0];
        if (rloc == 16'(16 * k + 6)) rddata_d = snap_q[k][31:16];
`ifdef ENC_INDEX_EN
        if (rloc == 16'(16 * k + 8))  rddata_d = index_q[k][15:0];
        if (rloc == 16'(16 * k + 10)) rddata_d = index_q[k][31:16];
`endif
      end
      if (rloc == 16'h0040) rddata_d = 16'(invert_q);
      if (rloc == 16'h0042) rddata_d = 16'(err_q);
      if (rloc == 16'h0044) rddata_d = {12'h000, flt_len_q};
`ifdef ENC_INDEX_EN
      if (rloc == 16'h0046) rddata_d = 16'(idx_seen_q);
`endif
    end
  end

  // Synchroniser flops run freely so reset can reload the filters from live inputs.
  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
  end

  // State registers; reset reloads filter/decoder state from the synchronised lines so no step is seen.
  always_ff @(posedge clk) begin
    if (sclr) begin
      flt_q     <= sync2_q;
      flt_len_q <= 4'd3;
      invert_q  <= '0;
      err_q     <= '0;
      chg_q     <= '0;
      rddata_q  <= '0;
      for (int i = 0; i < NLINE; i++) fcnt_q[i] <= '0;
      for (int k = 0; k < ENCODERS; k++) begin
        count_q[k] <= '0;
        snap_q[k]  <= '0;
      end
    end else begin
      flt_q     <= flt_d;
      flt_len_q <= flt_len_d;
      invert_q  <= invert_d;
      err_q     <= err_d;
      chg_q     <= chg_d;
      rddata_q  <= rddata_d;
      for (int i = 0; i < NLINE; i++) fcnt_q[i] <= fcnt_d[i];
      for (int k = 0; k < ENCODERS; k++) begin
        count_q[k] <= count_d[k];
        snap_q[k]  <= snap_d[k];
      end
    end
  end

`ifdef ENC_INDEX_EN
  // Index registers.
  always_ff @(posedge clk) begin
    if (sclr) begin
      idx_seen_q <= '0;
      for (int k = 0; k < ENCODERS; k++) index_q[k] <= '0;
    end else begin
      idx_seen_q <= idx_seen_d;
      for (int k = 0; k < ENCODERS; k++) index_q[k] <= index_d[k];
    end
  end
`endif

  assign rddata      = rddata_q;
  assign enc_changed = chg_q;
  assign enc_error   = |err_q;

endmodule

// File: tb/tb_enc_bus.sv
// tb_enc_bus: directed checks of enc_bus (2 channels, BAR 0x100, MASK 0xFF).
// Inputs driven 1 time unit after posedge, outputs sampled there too.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_enc_bus;

  localparam int E = 2;

  logic          clk = 1'b0;
  logic          sclr = 1'b1;
  logic [15:0]   rdaddr = '0;
  logic [15:0]   wraddr = '0;
  logic [1:0]    be = '0;
  logic          write = 1'b0;
  logic [15:0]   wrdata = '0;
  logic [15:0]   rddata;
  logic [E-1:0]  enc_a = '0;
  logic [E-1:0]  enc_b = '0;
  logic [E-1:0]  enc_z = '0;
  logic          global_snapshot = 1'b0;
  logic [E-1:0]  enc_changed;
  logic          enc_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enc_bus #(.ENCODERS(E), .BAR(16'h0100), .MASK(16'h00FF)) dut (
    .clk(clk), .sclr(sclr), .rdaddr(rdaddr), .wraddr(wraddr), .be(be),
    .write(write), .wrdata(wrdata), .rddata(rddata), .enc_a(enc_a),
    .enc_b(enc_b), .enc_z(enc_z), .global_snapshot(global_snapshot),
    .enc_changed(enc_changed), .enc_error(enc_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b);
    wraddr = a; wrdata = d; be = b; write = 1'b1;
    tick();
    write = 1'b0; be = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    rdaddr = a;
    tick();
    d = rddata;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    int pulses;
    enc_a = 2'b00; enc_b = 2'b10;   // channel 1 sits in state 01 across reset
    sclr = 1'b1;
    repeat (4) tick();
    sclr = 1'b0;
    checks++; if (rddata !== 16'h0) begin errors++; $display("FAIL reset_rddata got %h want 0000", rddata); end
    checks++; if (enc_changed !== 2'b00) begin errors++; $display("FAIL reset_changed got %b want 00", enc_changed); end
    checks++; if (enc_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", enc_error); end
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (enc_changed != 0) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_reload_pulses got %0d want 0", pulses); end
    bus_read(16'h0110, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_count1 got %h want 0000", d); end
    bus_read(16'h0144, d);
    checks++; if (d !== 16'h0003) begin errors++; $display("FAIL reset_flt got %h want 0003", d); end
    bus_read(16'h0140, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_invert got %h want 0000", d); end
    bus_read(16'h0142, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_err got %h want 0000", d); end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    logic [15:0] d;
    int lat, pulses;
    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    pulses = 0;
    for (int s = 0; s < 4; s++) begin
      lat = -1;
      enc_a[0] = seq[s][1]; enc_b[0] = seq[s][0];
      for (int n = 1; n <= 10; n++) begin
        tick();
        if (enc_changed[0]) begin
          pulses++;
          if (lat < 0) lat = n;
        end
      end
      checks++; if (lat !== 6) begin errors++; $display("FAIL fwd_latency step %0d got %0d want 6", s, lat); end
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL fwd_pulses got %0d want 4", pulses); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0004) begin errors++; $display("FAIL fwd_count_lo got %h want 0004", d); end
    bus_read(16'h0102, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL fwd_count_hi got %h want 0000", d); end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    bus_write(16'h0100, 16'h0000, 2'b11);
    bus_write(16'h0102, 16'h0000, 2'b11);
    enc_a[0] = 1'b1; enc_b[0] = 1'b0;          // 00 -> 10 is a reverse step
    repeat (10) tick();
    bus_read(16'h0100, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL wrap_neg_lo got %h want FFFF", d); end
    bus_read(16'h0102, d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL wrap_neg_hi got %h want FFFF", d); end
    bus_write(16'h0100, 16'hFFFF, 2'b11);
    bus_write(16'h0102, 16'h7FFF, 2'b11);
    enc_a[0] = 1'b0;                           // 10 -> 00 is a forward step
    repeat (10) tick();
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL wrap_pos_lo got %h want 0000", d); end
    bus_read(16'h0102, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL wrap_pos_hi got %h want 8000", d); end
    bus_write(16'h0100, 16'hAB12, 2'b01);
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0012) begin errors++; $display("FAIL byte_lo got %h want 0012", d); end
    bus_write(16'h0100, 16'hCD00, 2'b10);
    bus_read(16'h0100, d);
    checks++; if (d !== 16'hCD12) begin errors++; $display("FAIL byte_hi got %h want CD12", d); end
    bus_read(16'h0102, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL byte_upper got %h want 8000", d); end
  endtask

  task automatic test_invert();
    logic [15:0] d;
    int pulses;
    bus_write(16'h0140, 16'h0001, 2'b01);
    bus_read(16'h0140, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL invert_rd got %h want 0001", d); end
    pulses = 0;
    enc_b[0] = 1'b1;                           // 00 -> 01 forward, negated
    for (int n = 0; n < 10; n++) begin
      tick();
      if (enc_changed[0]) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL invert_pulses got %0d want 1", pulses); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'hCD11) begin errors++; $display("FAIL invert_count got %h want CD11", d); end
    bus_write(16'h0140, 16'h0000, 2'b01);
  endtask

  task automatic test_error();
    logic [15:0] d;
    int pulses;
    pulses = 0;
    enc_a[0] = 1'b1; enc_b[0] = 1'b0;          // 01 -> 10: both lines move together
    for (int n = 0; n < 10; n++) begin
      tick();
      if (enc_changed[0]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL err_pulses got %0d want 0", pulses); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'hCD11) begin errors++; $display("FAIL err_count got %h want CD11", d); end
    bus_read(16'h0142, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL err_flag got %h want 0001", d); end
    checks++; if (enc_error !== 1'b1) begin errors++; $display("FAIL err_out got %b want 1", enc_error); end
    bus_write(16'h0142, 16'h0001, 2'b01);
    bus_read(16'h0142, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL err_clear got %h want 0000", d); end
    checks++; if (enc_error !== 1'b0) begin errors++; $display("FAIL err_out_clear got %b want 0", enc_error); end
  endtask

  task automatic test_glitch();
    logic [15:0] d;
    int pulses;
    bus_write(16'h0100, 16'h0000, 2'b11);
    bus_write(16'h0102, 16'h0000, 2'b11);
    pulses = 0;
    enc_a[0] = 1'b0;
    repeat (2) tick();
    enc_a[0] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (enc_changed[0]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", pulses); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL glitch_count got %h want 0000", d); end
  endtask

  task automatic test_flt_zero();
    logic [15:0] d;
    int lat;
    bus_write(16'h0144, 16'h0000, 2'b01);
    bus_read(16'h0144, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL flt0_rd got %h want 0000", d); end
    lat = -1;
    enc_a[0] = 1'b0;                           // 10 -> 00 forward
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (enc_changed[0] && lat < 0) lat = n;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL flt0_latency got %0d want 3", lat); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL flt0_count got %h want 0001", d); end
    bus_write(16'h0144, 16'h0003, 2'b01);
  endtask

  task automatic test_snapshot();
    logic [15:0] d;
    bus_write(16'h0100, 16'd100, 2'b11);
    bus_write(16'h0102, 16'h0000, 2'b11);
    enc_b[0] = 1'b1;                           // 00 -> 01 forward
    repeat (5) tick();
    global_snapshot = 1'b1;
    tick();
    global_snapshot = 1'b0;
    checks++; if (enc_changed[0] !== 1'b1) begin errors++; $display("FAIL snap_coincide got %b want 1", enc_changed[0]); end
    bus_read(16'h0104, d);
    checks++; if (d !== 16'd100) begin errors++; $display("FAIL snap_lo got %0d want 100", d); end
    bus_read(16'h0106, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL snap_hi got %h want 0000", d); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'd101) begin errors++; $display("FAIL snap_count got %0d want 101", d); end
  endtask

  task automatic test_write_vs_step();
    logic [15:0] d;
    int pulses;
    enc_a[0] = 1'b1;                           // 01 -> 11 forward
    repeat (5) tick();
    wraddr = 16'h0100; wrdata = 16'h0200; be = 2'b11; write = 1'b1;
    tick();
    write = 1'b0; be = '0;
    checks++; if (enc_changed[0] !== 1'b0) begin errors++; $display("FAIL wr_step_changed got %b want 0", enc_changed[0]); end
    pulses = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (enc_changed[0]) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL wr_step_late_pulse got %0d want 0", pulses); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0200) begin errors++; $display("FAIL wr_step_count got %h want 0200", d); end
  endtask

  task automatic test_channel1_window();
    logic [15:0] d;
    enc_a[1] = 1'b1;                           // channel 1: 01 -> 11 forward
    repeat (10) tick();
    bus_read(16'h0110, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL ch1_count got %h want 0001", d); end
    bus_read(16'h0100, d);
    checks++; if (d !== 16'h0200) begin errors++; $display("FAIL ch0_isolated got %h want 0200", d); end
    bus_read(16'h0010, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL outside_read got %h want 0000", d); end
    bus_write(16'h0010, 16'h5555, 2'b11);
    bus_read(16'h0110, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL outside_write got %h want 0001", d); end
    bus_read(16'h0148, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL unmapped_read got %h want 0000", d); end
    bus_read(16'h0120, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL no_channel2 got %h want 0000", d); end
  endtask

  task automatic test_index();
    logic [15:0] d;
`ifdef ENC_INDEX_EN
    bus_write(16'h0100, 16'd37, 2'b11);
    bus_write(16'h0102, 16'h0000, 2'b11);
    enc_z[0] = 1'b1;
    repeat (10) tick();
    bus_read(16'h0108, d);
    checks++; if (d !== 16'd37) begin errors++; $display("FAIL index_lo got %0d want 37", d); end
    bus_read(16'h010A, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL index_hi got %h want 0000", d); end
    bus_read(16'h0146, d);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL idx_seen got %h want 0001", d); end
`else
    enc_z[0] = 1'b1;
    repeat (10) tick();
    bus_read(16'h0108, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL index_absent got %h want 0000", d); end
    bus_read(16'h0146, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL idx_seen_absent got %h want 0000", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_invert();
    test_error();
    test_glitch();
    test_flt_zero();
    test_snapshot();
    test_write_vs_step();
    test_channel1_window();
    test_index();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
